// File: rtl/sr_dbg_pkg.sv
// sr_dbg_pkg: shared constants and FSM encoding for the debug register dump.
// Optional feature macro: SR_REG_DUMP_CSUM_EN adds the CSUM state.
package sr_dbg_pkg;
    localparam int NUM_DBG_REGS = 32;
    localparam int AW = $clog2(NUM_DBG_REGS);
    localparam int IDX_W = 6;
    typedef enum logic [2:0] {
        IDLE,
        HALT,
        READ,
        SEND
`ifdef SR_REG_DUMP_CSUM_EN
        , CSUM
`endif
    } state_e;
endpackage

// File: rtl/sr_reg_dump.sv
// sr_reg_dump: halts the CPU, then streams debug registers 0..LAST_REG out over a valid/ready port.
// Optional feature macro: SR_REG_DUMP_CSUM_EN appends an XOR checksum word after the last register.
module sr_reg_dump
    import sr_dbg_pkg::*;
#(
    parameter int LAST_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    localparam logic [AW-1:0] LAST = AW'(LAST_REG);

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [31:0]      data_q, data_d;
    logic [IDX_W-1:0] oidx_q, oidx_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             hs;
`ifdef SR_REG_DUMP_CSUM_EN
    logic [31:0]      csum_q, csum_d;
`endif

    assign hs = out_valid & out_ready;

    // Next-state logic: sequence HALT -> READ -> SEND per register, capture word in READ.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef SR_REG_DUMP_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HALT;
                    idx_d   = '0;
`ifdef SR_REG_DUMP_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            HALT: state_d = READ;
            READ: begin
                data_d  = regData;
                oidx_d  = {1'b0, idx_q};
`ifdef SR_REG_DUMP_CSUM_EN
                last_d  = 1'b0;
`else
                last_d  = (idx_q == LAST);
`endif
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef SR_REG_DUMP_CSUM_EN
                    csum_d = csum_q ^ data_q;
`endif
                    if (idx_q == LAST) begin
`ifdef SR_REG_DUMP_CSUM_EN
                        state_d = CSUM;
                        data_d  = csum_q ^ data_q;
                        oidx_d  = IDX_W'(LAST_REG + 1);
                        last_d  = 1'b1;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
`ifdef SR_REG_DUMP_CSUM_EN
            CSUM: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset that drops any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SR_REG_DUMP_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            done_q  <= done_d;
`ifdef SR_REG_DUMP_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign regAddr  = (state_q == IDLE) ? '0 : idx_q;
    assign halt     = (state_q != IDLE);
    assign busy     = (state_q != IDLE);
`ifdef SR_REG_DUMP_CSUM_EN
    assign out_valid = (state_q == SEND) || (state_q == CSUM);
`else
    assign out_valid = (state_q == SEND);
`endif
    assign out_data = data_q;
    assign out_idx  = oidx_q;
    assign out_last = last_q;
    assign done     = done_q;
endmodule

// File: tb/tb_sr_reg_dump.sv
// tb_sr_reg_dump: directed bench for the debug register dump (full scan and LAST_REG=3 instance).
module tb_sr_reg_dump;
`ifdef SR_REG_DUMP_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif
    localparam int NW  = CS ? 33 : 32;
    localparam int NW3 = CS ? 5 : 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready, start3, out_ready3;
    logic [4:0]  reg_addr, reg_addr3;
    logic [31:0] reg_data, reg_data3, out_data, out_data3;
    logic        halt, out_valid, out_last, busy, done;
    logic        halt3, out_valid3, out_last3, busy3, done3;
    logic [5:0]  out_idx, out_idx3;
    int errs = 0;
    int checks = 0;

    function automatic logic [31:0] reg_val(logic [4:0] a);
        return (a == 5'd0) ? 32'h40 : 32'h11111111 * {27'd0, a};
    endfunction

    function automatic logic [31:0] csum_of(int last);
        logic [31:0] x = '0;
        for (int k = 0; k <= last; k++) x ^= reg_val(5'(k));
        return x;
    endfunction

    assign reg_data  = reg_val(reg_addr);
    assign reg_data3 = reg_val(reg_addr3);

    sr_reg_dump #(.LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .regAddr(reg_addr), .regData(reg_data),
        .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    sr_reg_dump #(.LAST_REG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .regAddr(reg_addr3), .regData(reg_data3),
        .halt(halt3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .out_idx(out_idx3), .out_last(out_last3), .busy(busy3), .done(done3)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid();
        for (int n = 0; n < 6 && out_valid !== 1'b1; n++) tick();
        chk("valid", 32'(out_valid), 32'd1);
    endtask

    task automatic check_word(int i);
        logic [31:0] exp_d;
        exp_d = (CS && i == 32) ? csum_of(31) : reg_val(5'(i));
        chk($sformatf("idx%0d", i), 32'(out_idx), 32'(i));
        chk($sformatf("data%0d", i), out_data, exp_d);
        chk($sformatf("last%0d", i), 32'(out_last), 32'(i == NW - 1));
        chk($sformatf("halt%0d", i), 32'(halt), 32'd1);
        chk($sformatf("busy%0d", i), 32'(busy), 32'd1);
        chk($sformatf("addr%0d", i), 32'(reg_addr), 32'(i > 31 ? 31 : i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start3 = 1'b0; out_ready3 = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        // full dump with backpressure at idx 7 and an ignored start at idx 12
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_state", 32'(halt), 32'd1);
        chk("halt_busy", 32'(busy), 32'd1);
        chk("halt_novalid", 32'(out_valid), 32'd0);
        tick();
        chk("read_novalid", 32'(out_valid), 32'd0);
        chk("read_addr", 32'(reg_addr), 32'd0);
        tick();
        chk("latency3", 32'(out_valid), 32'd1);
        for (int i = 0; i < NW; i++) begin
            wait_valid();
            check_word(i);
            if (i == 7) begin
                out_ready = 1'b0;
                repeat (10) begin
                    tick();
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_idx", 32'(out_idx), 32'd7);
                    chk("stall_data", out_data, reg_val(5'd7));
                end
                out_ready = 1'b1;
            end
            if (i == 12) start = 1'b1;
            tick();
            start = 1'b0;
            if (i < 31) chk("gap", 32'(out_valid), 32'd0);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_halt", 32'(halt), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        tick();
        chk("done_once", 32'(done), 32'd0);
        // reset mid-dump at idx 20
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            wait_valid();
            chk("pre_rst_idx", 32'(out_idx), 32'(i));
            if (i < 20) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_halt", 32'(halt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_addr", 32'(reg_addr), 32'd0);
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_idx", 32'(out_idx), 32'd0);
        chk("restart_data", out_data, 32'h40);
        // LAST_REG=3 with start held across done
        start3 = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < NW3; i++) begin
                for (int n = 0; n < 6 && out_valid3 !== 1'b1; n++) tick();
                chk("v3", 32'(out_valid3), 32'd1);
                chk("idx3", 32'(out_idx3), 32'(i));
                chk("data3", out_data3, (CS && i == 4) ? csum_of(3) : reg_val(5'(i)));
                chk("last3", 32'(out_last3), 32'(i == NW3 - 1));
                chk("halt3", 32'(halt3), 32'd1);
                tick();
            end
            chk("done3", 32'(done3), 32'd1);
            chk("done3_busy", 32'(busy3), 32'd0);
            if (rep == 0) begin
                tick();
                chk("rerun3_halt", 32'(halt3), 32'd1);
                chk("rerun3_busy", 32'(busy3), 32'd1);
                start3 = 1'b0;
            end
        end
        tick();
        chk("end3_done", 32'(done3), 32'd0);
        chk("end3_busy", 32'(busy3), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
